// File: rtl/text_overlay.sv
// text_overlay: maps the current draw coordinate to a character and glyph row for the
// 8x8 font ROM. It returns a registered text_on pixel flag two cycles later. It also
// handles per-frame message selection, 2x glyph scaling and a frame-based blink.
module text_overlay #(
    parameter int X0           = 216,
    parameter int Y0           = 232,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] drawX,
    input  logic [9:0] drawY,
    input  logic       frame_tick,
    input  logic       enable,
    input  logic       msg_sel,
    output logic [7:0] char_addr,
    output logic [2:0] row_addr,
    input  logic [7:0] bitmap,
    output logic       text_on
);

    localparam logic [10:0] X0_W      = 11'(X0);
    localparam logic [10:0] Y0_W      = 11'(Y0);
    localparam logic [7:0]  BLINK_MAX = 8'(BLINK_FRAMES - 1);
    localparam logic [7:0]  SPACE     = 8'h20;

    logic       msg_q;
    logic [7:0] blink_cnt;
    logic       visible;

    logic [10:0] len_px;
    logic        in_box;
    logic [7:0]  dx;
    logic [3:0]  dy;
    logic [3:0]  idx;
    logic [2:0]  bit_sel;
    logic [2:0]  row;

    logic        in_box_p1;
    logic [2:0]  bit_sel_p1;

    // Message ROM: one character per box slot, spaces past the end of the string.
    function automatic logic [7:0] msg_char(input logic sel, input logic [3:0] i);
        logic [7:0] c;
        c = SPACE;
        case ({sel, i})
            5'h00: c = 8'h50; // P
            5'h01: c = 8'h52; // R
            5'h02: c = 8'h45; // E
            5'h03: c = 8'h53; // S
            5'h04: c = 8'h53; // S
            5'h05: c = 8'h20;
            5'h06: c = 8'h41; // A
            5'h07: c = 8'h4E; // N
            5'h08: c = 8'h59; // Y
            5'h09: c = 8'h20;
            5'h0A: c = 8'h4B; // K
            5'h0B: c = 8'h45; // E
            5'h0C: c = 8'h59; // Y
            5'h10: c = 8'h50; // P
            5'h11: c = 8'h52; // R
            5'h12: c = 8'h45; // E
            5'h13: c = 8'h53; // S
            5'h14: c = 8'h53; // S
            5'h15: c = 8'h20;
            5'h16: c = 8'h53; // S
            5'h17: c = 8'h54; // T
            5'h18: c = 8'h41; // A
            5'h19: c = 8'h52; // R
            5'h1A: c = 8'h54; // T
            default: c = SPACE;
        endcase
        return c;
    endfunction

    // Box width in screen pixels: 16 pixels per character after 2x scaling.
    assign len_px = msg_q ? 11'd176 : 11'd208;

    // Widened compares so off-screen coordinates never wrap into the box.
    assign in_box = ({1'b0, drawX} >= X0_W) && ({1'b0, drawX} < X0_W + len_px) &&
                    ({1'b0, drawY} >= Y0_W) && ({1'b0, drawY} < Y0_W + 11'd16);

    // Only the low bits of the offsets are needed; the in_box test bounds the rest.
    assign dx      = drawX[7:0] - X0_W[7:0];
    assign dy      = drawY[3:0] - Y0_W[3:0];
    assign idx     = dx[7:4];
    assign bit_sel = dx[3:1];
    assign row     = dy[3:1];

    logic unused_bits;
    assign unused_bits = &{1'b0, dx[0], dy[0]};

    // Message selection only changes at frame start, so a frame never mixes strings.
    always_ff @(posedge clk) begin
        if (reset)
            msg_q <= 1'b0;
        else if (frame_tick)
            msg_q <= msg_sel;
    end

    // Blink timer: toggles visibility every BLINK_FRAMES frames; disabling rearms it visible.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            blink_cnt <= 8'd0;
            visible   <= 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt == BLINK_MAX) begin
                blink_cnt <= 8'd0;
                visible   <= ~visible;
            end else begin
                blink_cnt <= blink_cnt + 8'd1;
            end
        end
    end

    // ---- stage 1: font ROM address and pixel position within the glyph ----
    always_ff @(posedge clk) begin
        if (reset) begin
            char_addr  <= SPACE;
            row_addr   <= 3'd0;
            in_box_p1  <= 1'b0;
            bit_sel_p1 <= 3'd0;
        end else begin
            char_addr  <= in_box ? msg_char(msg_q, idx) : SPACE;
            row_addr   <= in_box ? row : 3'd0;
            in_box_p1  <= in_box;
            bit_sel_p1 <= bit_sel;
        end
    end

    // ---- stage 2: select the glyph bit (MSB = leftmost) and gate with blink/enable ----
    always_ff @(posedge clk) begin
        if (reset)
            text_on <= 1'b0;
        else
            text_on <= in_box_p1 & visible & enable & bitmap[3'd7 - bit_sel_p1];
    end

endmodule
